// File: rtl/mult_block_buffer.sv
// rtl/mult_block_buffer.sv - multiply / MAC engine that fills one memory block, then drains it
module mult_block_buffer #(
   parameter int IN_W   = 16,
   parameter int OUT_W  = 16,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              EN_mult,
   input  logic [IN_W-1:0]   mult_input0,
   input  logic [IN_W-1:0]   mult_input1,
   input  logic              mode_mac,
   input  logic              signed_op,
   input  logic              EN_flush,
   output logic              RDY_mult,
   output logic              EN_writeMem,
   output logic [ADDR_W-1:0] writeMem_addr,
   output logic [OUT_W-1:0]  writeMem_val,
   input  logic              EN_blockRead,
   output logic              EN_readMem,
   output logic [ADDR_W-1:0] readMem_addr,
   input  logic [OUT_W-1:0]  readMem_val,
   output logic              VALID_memVal,
   output logic [OUT_W-1:0]  memVal_data,
   output logic              memVal_last,
   output logic [ADDR_W:0]   blk_count
);

   // Accumulator carries one spare bit so unsigned sums stay non-negative in signed math.
   localparam int ACC_W = 2*IN_W + ADDR_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [1:0]              state;
   logic                    live;
   logic [ADDR_W:0]         cnt;
   logic                    mac_q;
   logic                    sgn_q;
   logic                    flush_pend;

   logic                    v1;
   logic [IN_W-1:0]         a_q;
   logic [IN_W-1:0]         b_q;
   logic [ADDR_W-1:0]       idx1;
   logic                    v2;
   logic signed [ACC_W-1:0] p_q;
   logic [ADDR_W-1:0]       idx2;
   logic signed [ACC_W-1:0] acc;

   logic                    wr_en;
   logic [ADDR_W-1:0]       wr_addr;
   logic [OUT_W-1:0]        wr_val;

   logic                    rd_en;
   logic [ADDR_W-1:0]       rd_addr;
   logic [RD_LAT-1:0]       vld_sr;
   logic [RD_LAT-1:0]       last_sr;

   logic                    rdy;
   logic                    accept;
   logic                    flush_now;
   logic                    close_blk;
   logic [ADDR_W:0]         last_addr;
   logic                    rd_is_last;
   logic signed [ACC_W-1:0] ea;
   logic signed [ACC_W-1:0] eb;
   logic signed [ACC_W-1:0] prod;
   logic signed [ACC_W-1:0] res;
   logic signed [ACC_W-1:0] umax;
   logic signed [ACC_W-1:0] smax;
   logic signed [ACC_W-1:0] smin;
   logic [OUT_W-1:0]        sat_val;

   // Handshake and block-control decisions for the current cycle.
   always_comb begin
      rdy        = live && ((state == S_IDLE) ||
                   ((state == S_FILL) && (cnt < DEPTH_C) && !flush_pend));
      accept     = EN_mult && rdy;
      flush_now  = EN_flush && (state == S_FILL) && ((cnt != '0) || accept);
      // The last operand must have left the operand stage; its write lands as the block closes.
      close_blk  = (state == S_FILL) && ((cnt == DEPTH_C) || flush_pend) && !v1;
      last_addr  = cnt - 1'b1;
      rd_is_last = rd_en && ({1'b0, rd_addr} == last_addr);
   end

   // Full-precision product, result selection and saturation to the stored width.
   always_comb begin
      if (sgn_q) begin
         ea = {{(ACC_W-IN_W){a_q[IN_W-1]}}, a_q};
         eb = {{(ACC_W-IN_W){b_q[IN_W-1]}}, b_q};
      end else begin
         ea = {{(ACC_W-IN_W){1'b0}}, a_q};
         eb = {{(ACC_W-IN_W){1'b0}}, b_q};
      end
      prod = ea * eb;
      res  = mac_q ? (acc + p_q) : p_q;
      umax = '0;
      umax[OUT_W-1:0] = '1;
      smax = '0;
      smax[OUT_W-2:0] = '1;
      smin = '1;
      smin[OUT_W-2:0] = '0;
      if (sgn_q) begin
         if (res > smax)      sat_val = smax[OUT_W-1:0];
         else if (res < smin) sat_val = smin[OUT_W-1:0];
         else                 sat_val = res[OUT_W-1:0];
      end else begin
         if (res > umax)      sat_val = '1;
         else                 sat_val = res[OUT_W-1:0];
      end
   end

   // Holds RDY_mult low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) live <= 1'b0;
      else      live <= 1'b1;
   end

   // Block state machine, accept counter, per-block mode latches and drain address generator.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         mac_q      <= 1'b0;
         sgn_q      <= 1'b0;
         flush_pend <= 1'b0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
      end else begin
         if (accept) cnt <= cnt + 1'b1;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_FILL;
                  mac_q <= mode_mac;
                  sgn_q <= signed_op;
               end
            end
            S_FILL: begin
               if (flush_now) flush_pend <= 1'b1;
               if (close_blk) begin
                  state      <= S_FULL;
                  flush_pend <= 1'b0;
               end
            end
            S_FULL: begin
               if (EN_blockRead) begin
                  state   <= S_DRAIN;
                  rd_en   <= 1'b1;
                  rd_addr <= '0;
               end
            end
            default: begin
               if (rd_en) begin
                  if (rd_is_last) rd_en   <= 1'b0;
                  else            rd_addr <= rd_addr + 1'b1;
               end
               if (vld_sr[RD_LAT-1] && last_sr[RD_LAT-1]) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end
            end
         endcase
      end
   end

   // Operand stage then product stage of the write pipeline.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1   <= 1'b0;
         a_q  <= '0;
         b_q  <= '0;
         idx1 <= '0;
         v2   <= 1'b0;
         p_q  <= '0;
         idx2 <= '0;
      end else begin
         v1 <= accept;
         if (accept) begin
            a_q  <= mult_input0;
            b_q  <= mult_input1;
            idx1 <= cnt[ADDR_W-1:0];
         end
         v2 <= v1;
         if (v1) begin
            p_q  <= prod;
            idx2 <= idx1;
         end
      end
   end

   // Accumulate and issue the memory write; the accumulator restarts from zero in IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc     <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_val  <= '0;
      end else begin
         wr_en <= v2;
         if (v2) begin
            wr_addr <= idx2;
            wr_val  <= sat_val;
            if (mac_q) acc <= res;
         end else if (state == S_IDLE) begin
            acc <= '0;
         end
      end
   end

   // Delay line aligning VALID/last with the memory read latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_sr  <= '0;
         last_sr <= '0;
      end else begin
         vld_sr[0]  <= rd_en;
         last_sr[0] <= rd_is_last;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_sr[i]  <= vld_sr[i-1];
            last_sr[i] <= last_sr[i-1];
         end
      end
   end

   assign RDY_mult      = rdy;
   assign EN_writeMem   = wr_en;
   assign writeMem_addr = wr_addr;
   assign writeMem_val  = wr_val;
   assign EN_readMem    = rd_en;
   assign readMem_addr  = rd_addr;
   assign VALID_memVal  = vld_sr[RD_LAT-1];
   assign memVal_data   = vld_sr[RD_LAT-1] ? readMem_val : '0;
   assign memVal_last   = vld_sr[RD_LAT-1] & last_sr[RD_LAT-1];
   assign blk_count     = cnt;

endmodule

// File: tb/tb_mult_block_buffer.sv
// tb/tb_mult_block_buffer.sv - directed self-checking bench for mult_block_buffer
module tb_mult_block_buffer;

   localparam int IN_W   = 16;
   localparam int OUT_W  = 16;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;
   localparam int RD_LAT = 2;

   logic              clk;
   logic              rst;
   logic              EN_mult;
   logic [IN_W-1:0]   mult_input0;
   logic [IN_W-1:0]   mult_input1;
   logic              mode_mac;
   logic              signed_op;
   logic              EN_flush;
   logic              RDY_mult;
   logic              EN_writeMem;
   logic [ADDR_W-1:0] writeMem_addr;
   logic [OUT_W-1:0]  writeMem_val;
   logic              EN_blockRead;
   logic              EN_readMem;
   logic [ADDR_W-1:0] readMem_addr;
   logic [OUT_W-1:0]  readMem_val;
   logic              VALID_memVal;
   logic [OUT_W-1:0]  memVal_data;
   logic              memVal_last;
   logic [ADDR_W:0]   blk_count;

   mult_block_buffer #(
      .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst(rst), .EN_mult(EN_mult), .mult_input0(mult_input0),
      .mult_input1(mult_input1), .mode_mac(mode_mac), .signed_op(signed_op),
      .EN_flush(EN_flush), .RDY_mult(RDY_mult), .EN_writeMem(EN_writeMem),
      .writeMem_addr(writeMem_addr), .writeMem_val(writeMem_val),
      .EN_blockRead(EN_blockRead), .EN_readMem(EN_readMem), .readMem_addr(readMem_addr),
      .readMem_val(readMem_val), .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
      .memVal_last(memVal_last), .blk_count(blk_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port sync-read memory with RD_LAT cycles of read latency.
   logic [OUT_W-1:0] mem [DEPTH];
   logic [OUT_W-1:0] rd_pipe [RD_LAT];
   int wr_cnt = 0;

   always @(posedge clk) begin
      if (EN_writeMem) begin
         mem[writeMem_addr] <= writeMem_val;
         wr_cnt <= wr_cnt + 1;
      end
      rd_pipe[0] <= EN_readMem ? mem[readMem_addr] : '0;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign readMem_val = rd_pipe[RD_LAT-1];

   int n_checks = 0;
   int n_fail   = 0;
   logic [OUT_W-1:0] exp_mem [DEPTH];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b, input logic fl);
      EN_mult     = 1'b1;
      mult_input0 = a;
      mult_input1 = b;
      EN_flush    = fl;
      tick();
      EN_mult  = 1'b0;
      EN_flush = 1'b0;
   endtask

   task automatic flush_pulse();
      EN_flush = 1'b1;
      tick();
      EN_flush = 1'b0;
   endtask

   task automatic drain(input int n, input string tag);
      EN_blockRead = 1'b1;
      tick();
      EN_blockRead = 1'b0;
      for (int c = 0; c < n + RD_LAT; c++) begin
         @(negedge clk);
         check({tag, "_ren"}, EN_readMem, c < n);
         if (c < n) check({tag, "_raddr"}, readMem_addr, c);
         check({tag, "_vld"}, VALID_memVal, c >= RD_LAT);
         if (c >= RD_LAT) begin
            check({tag, "_data"}, memVal_data, exp_mem[c-RD_LAT]);
            check({tag, "_last"}, memVal_last, c == n - 1 + RD_LAT);
         end
      end
      @(negedge clk);
      check({tag, "_end_rdy"}, RDY_mult, 1);
      check({tag, "_end_cnt"}, blk_count, 0);
      check({tag, "_end_ren"}, EN_readMem, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic found;
      rst = 1'b1; EN_mult = 0; mult_input0 = 0; mult_input1 = 0;
      mode_mac = 0; signed_op = 0; EN_flush = 0; EN_blockRead = 0;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rdy", RDY_mult, 0);
      check("rst_wen", EN_writeMem, 0);
      check("rst_ren", EN_readMem, 0);
      check("rst_vld", VALID_memVal, 0);
      check("rst_cnt", blk_count, 0);
      rst = 1'b1;
      #1 check("rdy_before_edge", RDY_mult, 0);
      tick();
      check("rdy_rise", RDY_mult, 1);

      // Unsigned multiply, full block of (i,3).
      for (int i = 0; i < DEPTH; i++) push(i[IN_W-1:0], 16'd3, 1'b0);
      check("a_rdy_low", RDY_mult, 0);
      check("a_cnt", blk_count, 64);
      push(16'd7, 16'd7, 1'b0);
      repeat (3) tick();
      push(16'd9, 16'd9, 1'b0);
      check("a_cnt_hold", blk_count, 64);
      check("a_wr_cnt", wr_cnt, 64);
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = OUT_W'(3 * i);
      drain(64, "a");

      // Signed multiply with saturation; signed_op change mid-block must not matter.
      mode_mac = 0; signed_op = 1;
      push(16'h8000, 16'h8000, 1'b0);
      push(16'hFFFF, 16'h0002, 1'b0);
      push(16'h0100, 16'h0100, 1'b0);
      push(16'h8000, 16'h0002, 1'b0);
      push(16'hFFFF, 16'hFFFF, 1'b0);
      signed_op = 0;
      push(16'hFFFF, 16'h0002, 1'b0);
      flush_pulse();
      repeat (3) tick();
      check("b_cnt", blk_count, 6);
      check("b_rdy_low", RDY_mult, 0);
      exp_mem[0] = 16'h7FFF; exp_mem[1] = 16'hFFFE; exp_mem[2] = 16'h7FFF;
      exp_mem[3] = 16'h8000; exp_mem[4] = 16'h0001; exp_mem[5] = 16'hFFFE;
      drain(6, "b");

      // Flush and block-read outside their states are ignored.
      EN_flush = 1; EN_blockRead = 1;
      tick();
      EN_flush = 0; EN_blockRead = 0;
      @(negedge clk);
      check("idle_ren", EN_readMem, 0);
      check("idle_rdy", RDY_mult, 1);
      check("idle_cnt", blk_count, 0);

      // Unsigned MAC, flush on the same cycle as the 5th accept.
      mode_mac = 1; signed_op = 0;
      for (int i = 0; i < 4; i++) push(16'd1, 16'd1, 1'b0);
      push(16'd1, 16'd1, 1'b1);
      check("c_cnt", blk_count, 5);
      check("c_rdy_low", RDY_mult, 0);
      tick();
      tick();
      check("c_wen", EN_writeMem, 1);
      check("c_waddr", writeMem_addr, 4);
      check("c_wval", writeMem_val, 5);
      for (int i = 0; i < 5; i++) exp_mem[i] = OUT_W'(i + 1);
      drain(5, "c");
      check("c_wr_cnt", wr_cnt, 75);

      // Next MAC block restarts the accumulator at zero.
      push(16'd2, 16'd3, 1'b0);
      push(16'd2, 16'd3, 1'b0);
      flush_pulse();
      repeat (3) tick();
      exp_mem[0] = 16'd6; exp_mem[1] = 16'd12;
      drain(2, "d");

      // Signed MAC: saturate on output only, accumulator keeps full precision.
      mode_mac = 1; signed_op = 1;
      push(16'h8000, 16'h7FFF, 1'b0);
      push(16'h7FFF, 16'h7FFF, 1'b0);
      flush_pulse();
      repeat (3) tick();
      exp_mem[0] = 16'h8000; exp_mem[1] = 16'h8001;
      drain(2, "e");

      // Reset in the middle of a drain.
      mode_mac = 0; signed_op = 0;
      for (int i = 0; i < 16; i++) push(i[IN_W-1:0], 16'd1, 1'b0);
      flush_pulse();
      repeat (3) tick();
      EN_blockRead = 1;
      tick();
      EN_blockRead = 0;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (EN_readMem && readMem_addr == 6'd10) found = 1'b1;
      end
      check("f_reach_addr10", found, 1);
      rst = 1'b0;
      #1;
      check("f_ren", EN_readMem, 0);
      check("f_vld", VALID_memVal, 0);
      check("f_rdy", RDY_mult, 0);
      check("f_cnt", blk_count, 0);
      check("f_wen", EN_writeMem, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("f_rdy_back", RDY_mult, 1);
      push(16'd5, 16'd5, 1'b0);
      flush_pulse();
      repeat (3) tick();
      check("f_cnt_new", blk_count, 1);
      exp_mem[0] = 16'd25;
      drain(1, "f");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
